// File: rtl/machine1_driver_if.sv
// rtl/machine1_driver_if.sv - command, machine1 drive/observe and status bundle for machine1_driver
interface machine1_driver_if #(
    parameter int STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_target;
    logic              X;
    logic              Y;
    logic              z1;
    logic              z2;
    logic              done;
    logic [STEP_W-1:0] steps;
    logic              err;
    logic              err_clr;

    // slave: the driver itself; master: whoever issues commands and plays machine1
    modport slave (
        input  cmd_valid, cmd_target, z1, z2, err_clr,
        output cmd_ready, X, Y, done, steps, err
    );
    modport master (
        output cmd_valid, cmd_target, z1, z2, err_clr,
        input  cmd_ready, X, Y, done, steps, err
    );
endinterface

// File: rtl/machine1_driver.sv
// rtl/machine1_driver.sv - walks machine1 to a commanded state; optional z1/z2 check via MACHINE1_DRV_CHECK_EN
module machine1_driver #(
    parameter int MAX_STEPS = 8,
    parameter int STEP_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    machine1_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } ctrl_t;

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_B = 3'd1;
    localparam logic [2:0] ST_C = 3'd2;
    localparam logic [2:0] ST_D = 3'd3;
    localparam logic [2:0] ST_E = 3'd4;
    localparam logic [2:0] ST_F = 3'd5;
    localparam logic [2:0] ST_G = 3'd6;
    localparam logic [2:0] ST_H = 3'd7;

    localparam logic [STEP_W-1:0] LP_MAX = STEP_W'(MAX_STEPS);

    ctrl_t             r_state;
    ctrl_t             w_state_nxt;
    logic [2:0]        r_shadow;
    logic [2:0]        w_shadow_nxt;
    logic [2:0]        r_target;
    logic [2:0]        w_target_nxt;
    logic [STEP_W-1:0] r_count;
    logic [STEP_W-1:0] w_count_nxt;
    logic              r_err;
    logic              w_timeout;
    logic              w_mismatch;
    logic              w_err_set;
    logic              w_at_target;
    logic              w_limit;
    logic [1:0]        w_hop;
    logic [1:0]        w_xy;

    assign w_at_target = (r_shadow == r_target);
    assign w_limit     = (r_count == LP_MAX);

    always_comb begin
        w_hop = 2'b00;
        case (r_shadow)
            ST_A:       w_hop = (r_target == ST_E || r_target == ST_F) ? 2'b01 : 2'b10;
            ST_B, ST_D: w_hop = 2'b10;
            ST_C:       w_hop = (r_target == ST_G || r_target == ST_H || r_target == ST_D) ? 2'b01 : 2'b10;
            default:    w_hop = 2'b00;
        endcase
    end

    // X/Y come only from registers; a timed-out step is not driven
    always_comb begin
        w_xy = 2'b00;
        if (r_state == S_RUN && !w_at_target && !w_limit) begin
            w_xy = w_hop;
        end
    end

    assign bus.X = w_xy[1];
    assign bus.Y = w_xy[0];

    always_comb begin
        w_shadow_nxt = r_shadow;
        case (r_shadow)
            ST_A:    w_shadow_nxt = w_xy[1] ? ST_B : (w_xy[0] ? ST_E : ST_A);
            ST_B:    w_shadow_nxt = w_xy[1] ? ST_D : ST_B;
            ST_C:    w_shadow_nxt = w_xy[1] ? ST_A : (w_xy[0] ? ST_G : ST_C);
            ST_D:    w_shadow_nxt = w_xy[1] ? ST_C : ST_D;
            ST_E:    w_shadow_nxt = ST_F;
            ST_F:    w_shadow_nxt = ST_B;
            ST_G:    w_shadow_nxt = ST_H;
            default: w_shadow_nxt = ST_D;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_count_nxt  = r_count;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_target_nxt = bus.cmd_target;
                    w_count_nxt  = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (w_at_target) begin
                    w_state_nxt = S_DONE;
                end else if (w_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_count + STEP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef MACHINE1_DRV_CHECK_EN
    logic [1:0] w_z_exp;

    always_comb begin
        w_z_exp = 2'b10;
        case (r_shadow)
            ST_D:             w_z_exp = 2'b00;
            ST_E, ST_G, ST_H: w_z_exp = 2'b11;
            default:          w_z_exp = 2'b10;
        endcase
    end

    assign w_mismatch = ({bus.z1, bus.z2} != w_z_exp);
`else
    logic w_unused_z;
    assign w_unused_z = bus.z1 ^ bus.z2;
    assign w_mismatch = 1'b0;
`endif

    assign w_err_set = w_mismatch | w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_shadow <= ST_A;
            r_target <= ST_A;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_target <= w_target_nxt;
            r_count  <= w_count_nxt;
            // a new error outranks a clear in the same cycle
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.steps     = (r_state == S_DONE) ? r_count : '0;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_machine1_driver.sv
// tb/tb_machine1_driver.sv - randomized and directed checks of machine1_driver against a route-level model
module tb_machine1_driver;

    localparam int STEP_W = 4;
    localparam int MAXS   = 8;
`ifdef MACHINE1_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    machine1_driver_if #(.STEP_W(STEP_W)) bus ();
    machine1_driver_if #(.STEP_W(STEP_W)) bus_t ();

    machine1_driver #(.MAX_STEPS(MAXS), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    machine1_driver #(.MAX_STEPS(4), .STEP_W(STEP_W)) dut_t (
        .clk(clk), .reset_n(reset_n), .bus(bus_t)
    );

    function automatic logic [2:0] nxt(input logic [2:0] s, input logic x, input logic y);
        case (s)
            3'd0:    return x ? 3'd1 : (y ? 3'd4 : 3'd0);
            3'd1:    return x ? 3'd3 : 3'd1;
            3'd2:    return x ? 3'd0 : (y ? 3'd6 : 3'd2);
            3'd3:    return x ? 3'd2 : 3'd3;
            3'd4:    return 3'd5;
            3'd5:    return 3'd1;
            3'd6:    return 3'd7;
            default: return 3'd3;
        endcase
    endfunction

    function automatic logic [1:0] hop(input logic [2:0] s, input logic [2:0] t);
        case (s)
            3'd0:       return (t == 3'd4 || t == 3'd5) ? 2'b01 : 2'b10;
            3'd1, 3'd3: return 2'b10;
            3'd2:       return (t == 3'd6 || t == 3'd7 || t == 3'd3) ? 2'b01 : 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] zexp(input logic [2:0] s);
        case (s)
            3'd3:             return 2'b00;
            3'd4, 3'd6, 3'd7: return 2'b11;
            default:          return 2'b10;
        endcase
    endfunction

    // machine1 stand-in for the timeout instance
    logic [2:0] t_sh;
    logic [1:0] t_z;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) t_sh <= 3'd0;
        else          t_sh <= nxt(t_sh, bus_t.X, bus_t.Y);
    end
    always_comb t_z = zexp(t_sh);
    assign bus_t.z1 = t_z[1];
    assign bus_t.z2 = t_z[0];

    typedef struct {
        logic x;
        logic y;
        logic done;
        int   steps;
        logic tmo;
    } ent_t;

    ent_t       q[$];
    logic [1:0] obs[$];
    logic [2:0] m_sh;
    logic       m_err;
    int         n_checks = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_x1 = 0;
    int         last_steps = -1;

    logic       d_valid, d_clr, d_corrupt;
    logic [2:0] d_target;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic x, input logic y, input logic dn, input int st, input logic tmo);
        ent_t e;
        e.x = x; e.y = y; e.done = dn; e.steps = st; e.tmo = tmo;
        q.push_back(e);
    endtask

    // expected per-cycle trace of a whole command, starting from the first RUN cycle
    task automatic build_route(input logic [2:0] start, input logic [2:0] t, input int maxs);
        logic [2:0] s;
        logic [1:0] h;
        int n;
        s = start;
        n = 0;
        for (int k = 0; k < 32; k++) begin
            if (s == t) begin
                push(1'b0, 1'b0, 1'b0, 0, 1'b0);
                push(1'b0, 1'b0, 1'b1, n, 1'b0);
                return;
            end
            if (n == maxs) begin
                push(1'b0, 1'b0, 1'b0, 0, 1'b1);
                return;
            end
            h = hop(s, t);
            push(h[1], h[0], 1'b0, 0, 1'b0);
            s = nxt(s, h[1], h[0]);
            n++;
        end
    endtask

    // called at a falling edge; compares, drives, advances the model, returns at the next falling edge
    task automatic cycle();
        logic busy, ex, ey, edn, tmo, mism;
        int est;
        logic [1:0] z;
        logic [2:0] nsh;
        busy = (q.size() != 0);
        ex = 1'b0; ey = 1'b0; edn = 1'b0; tmo = 1'b0; est = 0;
        if (busy) begin
            ex = q[0].x; ey = q[0].y; edn = q[0].done; est = q[0].steps; tmo = q[0].tmo;
        end
        chk("cmd_ready", int'(bus.cmd_ready), int'(!busy));
        chk("X", int'(bus.X), int'(ex));
        chk("Y", int'(bus.Y), int'(ey));
        chk("done", int'(bus.done), int'(edn));
        if (edn) chk("steps", int'(bus.steps), est);
        chk("err", int'(bus.err), int'(m_err));
        if (!bus.cmd_ready) obs.push_back({bus.X, bus.Y});
        if (bus.X) n_x1++;
        if (bus.done) begin
            n_done++;
            last_steps = int'(bus.steps);
        end

        z = zexp(m_sh);
        if (d_corrupt) z[0] = ~z[0];
        bus.cmd_valid  = d_valid;
        bus.cmd_target = d_target;
        bus.err_clr    = d_clr;
        bus.z1         = z[1];
        bus.z2         = z[0];

        @(posedge clk);
        mism = CHK && d_corrupt;
        if (mism || tmo) m_err = 1'b1;
        else if (d_clr)  m_err = 1'b0;
        nsh = nxt(m_sh, ex, ey);
        if (busy) void'(q.pop_front());
        else if (d_valid) build_route(nsh, d_target, MAXS);
        m_sh = nsh;
        @(negedge clk);
    endtask

    task automatic do_reset();
        d_valid = 1'b0; d_clr = 1'b0; d_corrupt = 1'b0; d_target = 3'd0;
        bus.cmd_valid = 1'b0; bus.err_clr = 1'b0;
        bus_t.cmd_valid = 1'b0; bus_t.err_clr = 1'b0; bus_t.cmd_target = 3'd0;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_sh = 3'd0;
        m_err = 1'b0;
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_X", int'(bus.X), 0);
        chk("rst_Y", int'(bus.Y), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_steps", int'(bus.steps), 0);
        chk("rst_err", int'(bus.err), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_cmd(input logic [2:0] t, input logic [2:0] t2, input logic hold);
        d_valid = 1'b1;
        d_target = t;
        cycle();
        d_target = t2;
        d_valid = hold;
        for (int i = 0; i < 24; i++) begin
            if (q.size() == 0) break;
            cycle();
        end
        if (q.size() != 0) chk("cmd_complete", 0, 1);
    endtask

    initial begin
        logic [1:0] lit[5];
        logic [1:0] lit_t[4];
        int done_before;

        reset_n = 1'b0;
        d_valid = 1'b0; d_clr = 1'b0; d_corrupt = 1'b0; d_target = 3'd0;
        bus.cmd_valid = 1'b0; bus.cmd_target = 3'd0; bus.err_clr = 1'b0;
        bus.z1 = 1'b1; bus.z2 = 1'b0;
        bus_t.cmd_valid = 1'b0; bus_t.cmd_target = 3'd0; bus_t.err_clr = 1'b0;
        m_sh = 3'd0; m_err = 1'b0;

        // pin the route model with hand-derived traces
        lit[0] = 2'b10; lit[1] = 2'b10; lit[2] = 2'b10; lit[3] = 2'b01; lit[4] = 2'b00;
        build_route(3'd0, 3'd7, 8);
        chk("model_AH_len", q.size(), 7);
        for (int i = 0; i < 5; i++) chk($sformatf("model_AH_hop%0d", i), int'({q[i].x, q[i].y}), int'(lit[i]));
        chk("model_AH_steps", q[6].steps, 5);
        q.delete();
        build_route(3'd1, 3'd5, 4);
        chk("model_BF_tmo", int'(q[q.size()-1].tmo), 1);
        chk("model_BF_len", q.size(), 5);
        q.delete();

        @(negedge clk);
        do_reset();

        // A -> D
        n_x1 = 0; last_steps = -1;
        run_cmd(3'd3, 3'd3, 1'b0);
        chk("t1_steps", last_steps, 2);
        chk("t1_x_cycles", n_x1, 2);
        chk("t1_shadow", int'(m_sh), 3);
        chk("t1_err", int'(bus.err), 0);
        cycle();

        // A -> H
        do_reset();
        obs.delete(); last_steps = -1;
        run_cmd(3'd7, 3'd7, 1'b0);
        chk("t2_steps", last_steps, 5);
        chk("t2_busy_cycles", obs.size(), 7);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_hop%0d", i), int'(obs[i]), int'(lit[i]));
        chk("t2_shadow", int'(m_sh), 3);

        // A -> A
        do_reset();
        obs.delete(); last_steps = -1; n_x1 = 0;
        run_cmd(3'd0, 3'd0, 1'b0);
        chk("t3_steps", last_steps, 0);
        chk("t3_busy_cycles", obs.size(), 2);
        chk("t3_x_cycles", n_x1, 0);

        // z mismatch while shadow is B
        do_reset();
        run_cmd(3'd1, 3'd1, 1'b0);
        cycle();
        d_corrupt = 1'b1;
        cycle();
        chk("t4_err_set", int'(bus.err), CHK ? 1 : 0);
        d_clr = 1'b1;
        cycle();
        chk("t4_err_hold", int'(bus.err), CHK ? 1 : 0);
        d_corrupt = 1'b0;
        cycle();
        chk("t4_err_clr", int'(bus.err), 0);
        d_clr = 1'b0;
        cycle();

        // reset mid-walk toward C
        do_reset();
        d_valid = 1'b1; d_target = 3'd2;
        cycle();
        d_valid = 1'b0;
        cycle();
        cycle();
        done_before = n_done;
        do_reset();
        cycle();
        chk("t5_no_done", n_done, done_before);
        last_steps = -1;
        run_cmd(3'd2, 3'd2, 1'b0);
        chk("t5_steps", last_steps, 3);

        // cmd_valid held through a command with another target
        do_reset();
        last_steps = -1;
        run_cmd(3'd3, 3'd7, 1'b1);
        chk("t6_first_steps", last_steps, 2);
        cycle();
        d_valid = 1'b0;
        chk("t6_second_accepted", int'(bus.cmd_ready), 0);
        for (int i = 0; i < 24; i++) begin
            if (q.size() == 0) break;
            cycle();
        end
        chk("t6_second_steps", last_steps, 3);

        // step-limit abort on the MAX_STEPS=4 instance: B -> F needs 5 hops
        do_reset();
        lit_t[0] = 2'b10; lit_t[1] = 2'b10; lit_t[2] = 2'b10; lit_t[3] = 2'b01;
        bus_t.cmd_valid = 1'b1; bus_t.cmd_target = 3'd1;
        cycle();
        bus_t.cmd_valid = 1'b0;
        chk("tt_hop_AB", int'({bus_t.X, bus_t.Y}), 2);
        cycle();
        chk("tt_at_B", int'({bus_t.cmd_ready, bus_t.X, bus_t.Y}), 0);
        cycle();
        chk("tt_done", int'(bus_t.done), 1);
        chk("tt_steps", int'(bus_t.steps), 1);
        cycle();
        chk("tt_idle", int'(bus_t.cmd_ready), 1);
        bus_t.cmd_valid = 1'b1; bus_t.cmd_target = 3'd5;
        cycle();
        bus_t.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tt_hop%0d", i), int'({bus_t.X, bus_t.Y}), int'(lit_t[i]));
            cycle();
        end
        chk("tt_limit_xy", int'({bus_t.X, bus_t.Y}), 0);
        chk("tt_limit_err_pre", int'(bus_t.err), 0);
        chk("tt_limit_ready", int'(bus_t.cmd_ready), 0);
        cycle();
        chk("tt_abort_ready", int'(bus_t.cmd_ready), 1);
        chk("tt_abort_err", int'(bus_t.err), 1);
        chk("tt_abort_done", int'(bus_t.done), 0);
        bus_t.err_clr = 1'b1;
        cycle();
        bus_t.err_clr = 1'b0;
        chk("tt_err_clr", int'(bus_t.err), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                d_valid   = ($urandom_range(0, 2) == 0);
                d_target  = 3'($urandom_range(0, 7));
                d_clr     = ($urandom_range(0, 15) == 0);
                d_corrupt = ($urandom_range(0, 31) == 0);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
